// File: rtl/zap_wb_burst_ram.sv
// zap_wb_burst_ram: Wishbone B3 slave RAM for ZAP cache clean/fill traffic (classic and
// incrementing bursts, WAIT_CYCLES wait states). Define ZAP_WB_RAM_ERR_EN for error termination.
module zap_wb_burst_ram #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic [31:0] i_wb_adr,
  input  logic        i_wb_wen,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_dat,
  input  logic [2:0]  i_wb_cti,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_dat,
  output logic        o_burst_active,
  output logic [7:0]  o_beat_ctr
);
  // Handshake: a beat is offered while cyc&stb and held by the master until it sees a one-cycle
  // ack/err; the master may drop cyc at any point to abandon the beat in flight.

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  CTI_INCR    = 3'b010;
  localparam logic [3:0]  WAIT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NO_WAIT     = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] { S_IDLE, S_WAIT, S_ACK } state_t;
  typedef struct packed {
    state_t     state;
    logic [3:0] wait_ctr;
  } fsm_t;

  fsm_t        fsm_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        wen_q;
  logic [3:0]  sel_q;
  logic [2:0]  cti_q;
  logic [31:0] mem [DEPTH];

  // The beat being serviced: live bus when completing straight from IDLE, captured copy otherwise.
  logic        in_idle;
  logic [31:0] b_adr;
  logic [31:0] b_dat;
  logic        b_wen;
  logic [3:0]  b_sel;
  logic [2:0]  b_cti;
  logic [29:0] b_word;
  logic [AW-1:0] b_idx;
  logic        b_in_range;
  logic        b_err;

  assign in_idle    = (fsm_q.state == S_IDLE);
  assign b_adr      = in_idle ? i_wb_adr : adr_q;
  assign b_dat      = in_idle ? i_wb_dat : dat_q;
  assign b_wen      = in_idle ? i_wb_wen : wen_q;
  assign b_sel      = in_idle ? i_wb_sel : sel_q;
  assign b_cti      = in_idle ? i_wb_cti : cti_q;
  assign b_word     = b_adr[31:2] - BASE_ADDR[31:2];
  assign b_idx      = b_word[AW-1:0];
  assign b_in_range = (b_adr >= BASE_ADDR) && ({2'b00, b_word} < 32'(DEPTH));

  logic go_ack;
  logic trk_step;
  logic trk_clear;
  logic mem_we;

`ifdef ZAP_WB_RAM_ERR_EN
  // Expected next address and direction only matter when violations are terminated with err.
  logic [29:0] exp_word_q;
  logic        burst_wen_q;
  logic        b_seq_err;

  assign b_seq_err = o_burst_active &&
                     ((b_adr[31:2] != exp_word_q) || (b_wen != burst_wen_q) || (b_cti == CTI_CLASSIC));
  assign b_err     = !b_in_range || b_seq_err;
  assign trk_step  = (b_cti == CTI_INCR) && !b_seq_err;
`else
  assign b_err     = 1'b0;
  assign trk_step  = (b_cti == CTI_INCR);
  assign o_wb_err  = 1'b0;
`endif

  assign go_ack    = i_wb_cyc && ((in_idle && i_wb_stb && NO_WAIT) ||
                                  (fsm_q.state == S_WAIT && fsm_q.wait_ctr == 4'd0));
  assign trk_clear = (!i_wb_cyc && fsm_q.state != S_ACK) || (go_ack && !trk_step);
  assign mem_we    = i_reset_n && go_ack && b_wen && b_in_range && !b_err;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fsm_q          <= '{state: S_IDLE, wait_ctr: 4'd0};
      adr_q          <= '0;
      dat_q          <= '0;
      wen_q          <= 1'b0;
      sel_q          <= '0;
      cti_q          <= '0;
      o_wb_ack       <= 1'b0;
      o_wb_dat       <= '0;
      o_burst_active <= 1'b0;
      o_beat_ctr     <= '0;
`ifdef ZAP_WB_RAM_ERR_EN
      o_wb_err       <= 1'b0;
      exp_word_q     <= '0;
      burst_wen_q    <= 1'b0;
`endif
    end else begin
      o_wb_ack <= 1'b0;
`ifdef ZAP_WB_RAM_ERR_EN
      o_wb_err <= 1'b0;
`endif
      case (fsm_q.state)
        S_IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            adr_q          <= i_wb_adr;
            dat_q          <= i_wb_dat;
            wen_q          <= i_wb_wen;
            sel_q          <= i_wb_sel;
            cti_q          <= i_wb_cti;
            fsm_q.state    <= NO_WAIT ? S_ACK : S_WAIT;
            fsm_q.wait_ctr <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (!i_wb_cyc) begin
            fsm_q.state <= S_IDLE;
          end else if (fsm_q.wait_ctr == 4'd0) begin
            fsm_q.state <= S_ACK;
          end else begin
            fsm_q.wait_ctr <= fsm_q.wait_ctr - 4'd1;
          end
        end
        default: fsm_q.state <= S_IDLE;
      endcase

      if (go_ack) begin
`ifdef ZAP_WB_RAM_ERR_EN
        o_wb_err <= b_err;
        o_wb_ack <= !b_err;
`else
        o_wb_ack <= 1'b1;
`endif
        if (!b_wen && !b_err) begin
          o_wb_dat <= b_in_range ? mem[b_idx] : '0;
        end
      end

      if (trk_clear) begin
        o_burst_active <= 1'b0;
        o_beat_ctr     <= '0;
      end else if (go_ack) begin
        o_burst_active <= 1'b1;
        o_beat_ctr     <= (o_beat_ctr == 8'hFF) ? o_beat_ctr : o_beat_ctr + 8'd1;
`ifdef ZAP_WB_RAM_ERR_EN
        exp_word_q     <= b_adr[31:2] + 30'd1;
        burst_wen_q    <= b_wen;
`endif
      end
    end
  end

  // Storage is deliberately not reset; only selected bytes are written.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (b_sel[b]) mem[b_idx][8*b +: 8] <= b_dat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_zap_wb_burst_ram.sv
// Bench for zap_wb_burst_ram: a zero-wait instance and a 3-wait instance with offset base,
// each beat compared against a word-level memory/burst reference kept here.
module tb_zap_wb_burst_ram;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef ZAP_WB_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int unsigned DEPTHS [2] = '{1024, 16};
  localparam int unsigned WAITS  [2] = '{0, 3};
  localparam logic [31:0] BASES  [2] = '{32'h0, 32'h1000};

  logic [31:0] adr  = '0;
  logic [31:0] wdat = '0;
  logic        wen  = 1'b0;
  logic [3:0]  sel  = '0;
  logic [2:0]  cti  = '0;
  logic        cyc0 = 1'b0, stb0 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
  logic        ack0, err0, act0, ack3, err3, act3;
  logic [31:0] rdat0, rdat3;
  logic [7:0]  bctr0, bctr3;

  zap_wb_burst_ram #(.DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc0), .i_wb_stb(stb0), .i_wb_adr(adr),
    .i_wb_wen(wen), .i_wb_sel(sel), .i_wb_dat(wdat), .i_wb_cti(cti), .o_wb_ack(ack0),
    .o_wb_err(err0), .o_wb_dat(rdat0), .o_burst_active(act0), .o_beat_ctr(bctr0));

  zap_wb_burst_ram #(.DEPTH(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h1000)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc3), .i_wb_stb(stb3), .i_wb_adr(adr),
    .i_wb_wen(wen), .i_wb_sel(sel), .i_wb_dat(wdat), .i_wb_cti(cti), .o_wb_ack(ack3),
    .o_wb_err(err3), .o_wb_dat(rdat3), .o_burst_active(act3), .o_beat_ctr(bctr3));

  // Reference model
  int unsigned n_checks = 0, n_pass = 0, n_fail = 0;
  logic [31:0] m_mem [2][1024];
  bit          m_active [2];
  int          m_ctr [2];
  logic [31:0] m_exp [2];
  bit          m_wen [2];
  logic [31:0] m_dat [2];
  bit          in_ack [2];

  function automatic logic f_ack(input int u); return (u == 0) ? ack0 : ack3; endfunction
  function automatic logic f_err(input int u); return (u == 0) ? err0 : err3; endfunction
  function automatic logic f_act(input int u); return (u == 0) ? act0 : act3; endfunction
  function automatic logic [31:0] f_dat(input int u); return (u == 0) ? rdat0 : rdat3; endfunction
  function automatic logic [7:0] f_ctr(input int u); return (u == 0) ? bctr0 : bctr3; endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_tracker(input int u, input string tag);
    check({tag, "_active"}, 32'(f_act(u)), 32'(m_active[u]));
    check({tag, "_beat_ctr"}, 32'(f_ctr(u)), 32'(m_ctr[u]));
  endtask

  task automatic check_zero(input int u, input string tag);
    check({tag, "_ack"}, 32'(f_ack(u)), 32'h0);
    check({tag, "_err"}, 32'(f_err(u)), 32'h0);
    check({tag, "_dat"}, f_dat(u), 32'h0);
    check({tag, "_active"}, 32'(f_act(u)), 32'h0);
    check({tag, "_beat_ctr"}, 32'(f_ctr(u)), 32'h0);
  endtask

  task automatic set_req(input int u, input logic v);
    if (u == 0) begin cyc0 = v; stb0 = v; end
    else begin cyc3 = v; stb3 = v; end
  endtask

  task automatic drive(input int u, input logic [31:0] a, input bit w, input logic [3:0] s,
                       input logic [31:0] d, input logic [2:0] c);
    adr = a; wen = w; sel = s; wdat = d; cti = c;
    set_req(u, 1'b1);
  endtask

  task automatic clear_tracker(input int u);
    m_active[u] = 1'b0;
    m_ctr[u]    = 0;
  endtask

  // One full beat: expectations derived from address range, burst rules and the model memory.
  task automatic beat(input int u, input logic [31:0] a, input bit w, input logic [3:0] s,
                      input logic [31:0] d, input logic [2:0] c, input bit last);
    bit inr, viol, e;
    int lat, n;
    logic [31:0] idx;
    inr  = (a >= BASES[u]) && (((a - BASES[u]) >> 2) < DEPTHS[u]);
    idx  = (a - BASES[u]) >> 2;
    viol = m_active[u] && ((a[31:2] != m_exp[u][31:2]) || (w != m_wen[u]) || (c == 3'b000));
    e    = ERR_EN && (!inr || viol);
    lat  = int'(WAITS[u]) + 1 + (in_ack[u] ? 1 : 0);
    drive(u, a, w, s, d, c);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(f_ack(u) || f_err(u)) && n < 40);
    check("latency", 32'(n), 32'(lat));
    check("ack", 32'(f_ack(u)), 32'(!e));
    check("err", 32'(f_err(u)), 32'(e));
    if (!e && inr && w) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_mem[u][idx][8*b +: 8] = d[8*b +: 8];
    end
    if (!e && !w) m_dat[u] = inr ? m_mem[u][idx] : 32'h0;
    check("rdata", f_dat(u), m_dat[u]);
    if ((ERR_EN && viol) || c != 3'b010) begin
      clear_tracker(u);
    end else begin
      m_active[u] = 1'b1;
      m_exp[u]    = a + 32'd4;
      m_wen[u]    = w;
      m_ctr[u]    = (m_ctr[u] < 255) ? m_ctr[u] + 1 : 255;
    end
    check_tracker(u, "beat");
    if (last) begin
      set_req(u, 1'b0);
      @(posedge clk); #1;
      check("ack_width", {30'b0, f_ack(u), f_err(u)}, 32'h0);
      @(posedge clk); #1;
      clear_tracker(u);
      in_ack[u] = 1'b0;
      check_tracker(u, "cyc_drop");
    end else begin
      in_ack[u] = 1'b1;
    end
  endtask

  // Offer a beat, then drop cyc two cycles after it was accepted.
  task automatic abort_beat(input int u, input logic [31:0] a, input bit w, input logic [31:0] d);
    drive(u, a, w, 4'hF, d, 3'b010);
    if (in_ack[u]) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
    set_req(u, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_no_ack", {30'b0, f_ack(u), f_err(u)}, 32'h0);
    end
    clear_tracker(u);
    in_ack[u] = 1'b0;
    check_tracker(u, "abort");
  endtask

  // Offer a write, assert reset while it waits; outputs must clear at once.
  task automatic reset_mid_beat(input int u, input logic [31:0] a, input logic [31:0] d);
    drive(u, a, 1'b1, 4'hF, d, 3'b000);
    if (in_ack[u]) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_zero(0, "mid_reset0");
    check_zero(1, "mid_reset3");
    set_req(u, 1'b0);
    for (int v = 0; v < 2; v++) begin
      clear_tracker(v);
      m_dat[v]  = 32'h0;
      in_ack[v] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int v = 0; v < 2; v++) begin
      clear_tracker(v);
      m_exp[v]  = '0;
      m_wen[v]  = 1'b0;
      m_dat[v]  = '0;
      in_ack[v] = 1'b0;
    end

    // Reset held with a live request on both instances
    rst_n = 1'b0;
    adr   = 32'h1000;
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check_zero(0, "reset0");
      check_zero(1, "reset3");
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Classic byte-lane write then read
    beat(0, 32'h40, 1'b1, 4'hF, 32'h0, 3'b000, 1'b1);
    beat(0, 32'h40, 1'b1, 4'b0101, 32'hDEADBEEF, 3'b000, 1'b1);
    beat(0, 32'h40, 1'b0, 4'hF, 32'h0, 3'b000, 1'b1);
    check("byte_lane_read", rdat0, 32'h00AD00EF);

    // Clean 4-beat write burst, then read the words back
    for (int i = 0; i < 4; i++)
      beat(0, 32'h100 + 32'(4*i), 1'b1, 4'hF, 32'(i + 1), (i == 3) ? 3'b111 : 3'b010, i == 3);
    for (int i = 0; i < 4; i++)
      beat(0, 32'h100 + 32'(4*i), 1'b0, 4'hF, 32'h0, 3'b000, 1'b1);

    // Burst address violation: 0x0 then 0x8
    beat(0, 32'h8, 1'b1, 4'hF, 32'h22222222, 3'b000, 1'b1);
    beat(0, 32'h0, 1'b1, 4'hF, 32'h11111111, 3'b010, 1'b0);
    beat(0, 32'h8, 1'b1, 4'hF, 32'h88888888, 3'b010, 1'b1);
    beat(0, 32'h8, 1'b0, 4'hF, 32'h0, 3'b000, 1'b1);

    // Just past the end, and a burst whose expected address wraps to 0
    beat(0, 32'h1000, 1'b0, 4'hF, 32'h0, 3'b000, 1'b1);
    beat(0, 32'hFFFFFFFC, 1'b0, 4'hF, 32'h0, 3'b010, 1'b0);
    beat(0, 32'h0, 1'b0, 4'hF, 32'h0, 3'b111, 1'b1);

    // Long burst: beat counter saturates at 255
    for (int i = 0; i < 260; i++)
      beat(0, 32'h800 + 32'(4*i), 1'b1, 4'hF, 32'(i), (i == 259) ? 3'b111 : 3'b010, i == 259);

    // Wait-state instance: latency, abort, range edges, reset during a beat
    beat(1, 32'h1000, 1'b1, 4'hF, 32'h11111111, 3'b000, 1'b1);
    beat(1, 32'h1008, 1'b1, 4'hF, 32'h33333333, 3'b000, 1'b1);
    beat(1, 32'h103C, 1'b1, 4'hF, 32'hCAFEF00D, 3'b000, 1'b1);
    beat(1, 32'h1000, 1'b0, 4'hF, 32'h0, 3'b000, 1'b1);
    abort_beat(1, 32'h1000, 1'b1, 32'hBAD0BAD0);
    beat(1, 32'h1000, 1'b0, 4'hF, 32'h0, 3'b000, 1'b1);
    beat(1, 32'h1004, 1'b1, 4'hF, 32'h22222222, 3'b010, 1'b0);
    abort_beat(1, 32'h1008, 1'b1, 32'hBAD1BAD1);
    beat(1, 32'h1008, 1'b0, 4'hF, 32'h0, 3'b000, 1'b1);
    beat(1, 32'h1040, 1'b0, 4'hF, 32'h0, 3'b000, 1'b1);
    beat(1, 32'h0FFC, 1'b0, 4'hF, 32'h0, 3'b000, 1'b1);
    beat(1, 32'h103C, 1'b0, 4'hF, 32'h0, 3'b010, 1'b0);
    reset_mid_beat(1, 32'h1000, 32'hDEAD0000);
    beat(1, 32'h1000, 1'b0, 4'hF, 32'h0, 3'b000, 1'b1);

    // Randomised traffic over a pre-initialised window
    for (int i = 0; i < 16; i++)
      beat(0, 32'(4*i), 1'b1, 4'hF, $urandom, 3'b000, 1'b1);
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      logic [2:0]  c;
      bit          w, last;
      case ($urandom_range(0, 2))
        0:       c = 3'b000;
        1:       c = 3'b010;
        default: c = 3'b111;
      endcase
      if (m_active[0] && m_exp[0] < 32'h40 && $urandom_range(0, 3) != 0) a = m_exp[0];
      else if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'(4*$urandom_range(0, 3));
      else a = 32'(4*$urandom_range(0, 15));
      w    = 1'($urandom_range(0, 1));
      last = ($urandom_range(0, 3) == 0);
      beat(0, a, w, 4'($urandom_range(0, 15)), $urandom, c, last);
    end
    beat(0, 32'h3C, 1'b0, 4'hF, 32'h0, 3'b111, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
